// File: rtl/mu0_mux_arb_pkg.sv
// mu0_mux_arb_pkg
//   Shared constants for the MU0 arbitrated multiplexer:
//     DEF_WIDTH, DEF_CHANNELS : default channel data width and channel count
//     RR_MODE, FIXED_MODE     : arbitration mode selectors (round-robin / fixed priority)
//   Helper function wrap_inc() gives an exact modulo-N increment for any N,
//   including non-power-of-two channel counts.
package mu0_mux_arb_pkg;

  localparam int DEF_WIDTH    = 12;
  localparam int DEF_CHANNELS = 2;

  localparam int RR_MODE    = 1;
  localparam int FIXED_MODE = 0;

  // Increment idx by one, wrapping from n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    int res;
    if (idx >= n - 1) begin
      res = 0;
    end else begin
      res = idx + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mu0_rr_arbiter.sv
// mu0_rr_arbiter
//   Winner selection among CHANNELS requesters.
//   RR = RR_MODE    : first requester at or above the rotating pointer, wrapping.
//   RR = FIXED_MODE : lowest-numbered requester wins; the pointer stays at 0.
// Ports:
//   Clk         : clock, rising edge
//   nReset      : asynchronous active-low reset (pointer -> 0)
//   req         : per-channel request vector
//   advance     : the consumer can take a word this cycle; the pointer moves
//                 past the winner only when a grant is actually taken
//   grant_idx   : index of the winning channel (0 when nothing is requested)
//   grant_valid : at least one request is present
module mu0_rr_arbiter
  import mu0_mux_arb_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int RR       = RR_MODE,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                Clk,
  input  logic                nReset,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                grant_valid
);

  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] grant_idx_s;
  logic             grant_valid_s;
  logic [SEL_W-1:0] ptr_next_s;
  int               dist_v;
  int               best_dist_v;

  // Winner search: each requester is ranked by its upward distance from the
  // pointer (fixed mode ranks by index); the smallest distance wins.
  always_comb begin
    grant_idx_s   = '0;
    grant_valid_s = 1'b0;
    dist_v        = 0;
    best_dist_v   = CHANNELS;
    for (int i = 0; i < CHANNELS; i++) begin
      if (RR == RR_MODE) begin
        if (i >= int'(ptr_r)) begin
          dist_v = i - int'(ptr_r);
        end else begin
          dist_v = i + CHANNELS - int'(ptr_r);
        end
      end else begin
        dist_v = i;
      end
      if (req[i] && (dist_v < best_dist_v)) begin
        best_dist_v   = dist_v;
        grant_idx_s   = SEL_W'(i);
        grant_valid_s = 1'b1;
      end else begin
        best_dist_v   = best_dist_v;
      end
    end
  end

  // Pointer successor of the current winner, wrapping exactly at CHANNELS-1.
  always_comb begin
    ptr_next_s = SEL_W'(wrap_inc(int'(grant_idx_s), CHANNELS));
  end

  // Rotating pointer: moves past the winner on every taken grant, else holds.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      ptr_r <= '0;
    end else if ((RR == RR_MODE) && advance && grant_valid_s) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign grant_idx   = grant_idx_s;
  assign grant_valid = grant_valid_s;

endmodule

// File: rtl/mu0_mux_arb.sv
// mu0_mux_arb
//   Arbitrated N:1 multiplexer with a single registered output stage.
//   One word per cycle can move from the winning channel into Q whenever the
//   output register is empty or being drained in the same cycle.
// Ports:
//   Clk      : clock, rising edge
//   nReset   : asynchronous active-low reset
//   In_valid : per-channel request flags
//   In_data  : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   In_ready : per-channel accept (combinational, never depends on In_data)
//   Q        : registered selected data
//   Q_valid  : Q holds a word not yet taken
//   Q_ready  : downstream takes Q this cycle
//   Sel      : registered index of the channel whose word is in Q
module mu0_mux_arb
  import mu0_mux_arb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int RR       = RR_MODE,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      Clk,
  input  logic                      nReset,
  input  logic [CHANNELS-1:0]       In_valid,
  input  logic [CHANNELS*WIDTH-1:0] In_data,
  output logic [CHANNELS-1:0]       In_ready,
  output logic [WIDTH-1:0]          Q,
  output logic                      Q_valid,
  input  logic                      Q_ready,
  output logic [SEL_W-1:0]          Sel
);

  logic [WIDTH-1:0] q_r;
  logic             q_valid_r;
  logic [SEL_W-1:0] sel_r;

  logic             load_s;
  logic [SEL_W-1:0] grant_idx_s;
  logic             grant_valid_s;
  logic [WIDTH-1:0] sel_data_s;

  // The output register can accept a new word when empty or draining now.
  assign load_s = (~q_valid_r) | Q_ready;

  mu0_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .RR       (RR)
  ) u_arb (
    .Clk         (Clk),
    .nReset      (nReset),
    .req         (In_valid),
    .advance     (load_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // Accept strobe for the winner; forced low while reset is held because
  // the empty output register would otherwise report itself as loadable.
  always_comb begin
    In_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (nReset && load_s && grant_valid_s && In_valid[i] &&
          (grant_idx_s == SEL_W'(i))) begin
        In_ready[i] = 1'b1;
      end else begin
        In_ready[i] = 1'b0;
      end
    end
  end

  // Data multiplexer: pick the winning channel's slice of the packed bus.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx_s == SEL_W'(i)) begin
        sel_data_s = In_data[i*WIDTH +: WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Output stage: load the winner, go empty when nothing is requested
  // (keeping the last word and index), or hold under backpressure.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      q_r       <= '0;
      sel_r     <= '0;
      q_valid_r <= 1'b0;
    end else if (load_s) begin
      if (grant_valid_s) begin
        q_r       <= sel_data_s;
        sel_r     <= grant_idx_s;
        q_valid_r <= 1'b1;
      end else begin
        q_r       <= q_r;
        sel_r     <= sel_r;
        q_valid_r <= 1'b0;
      end
    end else begin
      q_r       <= q_r;
      sel_r     <= sel_r;
      q_valid_r <= q_valid_r;
    end
  end

  assign Q       = q_r;
  assign Q_valid = q_valid_r;
  assign Sel     = sel_r;

endmodule

// File: tb/tb_mu0_mux_arb.sv
// tb_mu0_mux_arb
//   Two instances share one stimulus stream: u_rr (round-robin) and u_fix
//   (fixed priority), both WIDTH=12, CHANNELS=4. A reference model computes
//   the expected accept vector each cycle and pushes every accepted word onto
//   a per-instance queue; independent monitors pop and compare whenever the
//   DUT's output word is taken.
module tb_mu0_mux_arb;

  localparam int W = 12;
  localparam int N = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic [1:0]   s;
  } exp_t;

  logic           Clk = 1'b0;
  logic           nReset;
  logic [N-1:0]   In_valid;
  logic [N*W-1:0] In_data;
  logic           Q_ready;

  logic [N-1:0] rdy_a, rdy_b;
  logic [W-1:0] q_a, q_b;
  logic         qv_a, qv_b;
  logic [1:0]   sel_a, sel_b;

  int checks = 0;
  int errors = 0;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t mon_a;
  exp_t mon_b;

  // Reference model state, index 0 = round-robin, 1 = fixed priority
  int           ptr_m[2];
  bit           qv_m[2];
  logic [W-1:0] lq_m[2];
  logic [1:0]   ls_m[2];

  always #5 Clk = ~Clk;

  mu0_mux_arb #(.WIDTH(W), .CHANNELS(N), .RR(1)) u_rr (
    .Clk(Clk), .nReset(nReset), .In_valid(In_valid), .In_data(In_data),
    .In_ready(rdy_a), .Q(q_a), .Q_valid(qv_a), .Q_ready(Q_ready), .Sel(sel_a)
  );

  mu0_mux_arb #(.WIDTH(W), .CHANNELS(N), .RR(0)) u_fix (
    .Clk(Clk), .nReset(nReset), .In_valid(In_valid), .In_data(In_data),
    .In_ready(rdy_b), .Q(q_b), .Q_valid(qv_b), .Q_ready(Q_ready), .Sel(sel_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Winner by definition: scan channels starting at p (or at 0 for fixed).
  function automatic int pick(input logic [N-1:0] v, input int p, input bit rr);
    int c;
    for (int k = 0; k < N; k++) begin
      c = rr ? (p + k) % N : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic eval_dut(input int m, input logic [N-1:0] rdy, input logic [W-1:0] q,
                          input logic qv, input logic [1:0] sel);
    logic [N-1:0] erdy;
    int           w;
    bit           load;
    exp_t         e;
    string        tag;
    tag = (m == 0) ? "rr" : "fix";
    if (nReset !== 1'b1) begin
      chk({tag, "_rst_in_ready"}, 32'(rdy), 32'd0);
      chk({tag, "_rst_q"},        32'(q),   32'd0);
      chk({tag, "_rst_q_valid"},  32'(qv),  32'd0);
      chk({tag, "_rst_sel"},      32'(sel), 32'd0);
      ptr_m[m] = 0;
      qv_m[m]  = 1'b0;
      lq_m[m]  = '0;
      ls_m[m]  = '0;
      if (m == 0) exp_a.delete();
      else        exp_b.delete();
    end else begin
      load = !qv_m[m] || (Q_ready === 1'b1);
      w    = pick(In_valid, ptr_m[m], m == 0);
      erdy = (load && w >= 0) ? (4'b0001 << w) : 4'b0000;
      chk({tag, "_in_ready"}, 32'(rdy), 32'(erdy));
      chk({tag, "_q_valid"},  32'(qv),  32'(qv_m[m]));
      chk({tag, "_q_hold"},   32'(q),   32'(lq_m[m]));
      chk({tag, "_sel_hold"}, 32'(sel), 32'(ls_m[m]));
      if (load) begin
        if (w >= 0) begin
          e.d = In_data[w*W +: W];
          e.s = w[1:0];
          if (m == 0) exp_a.push_back(e);
          else        exp_b.push_back(e);
          lq_m[m]  = e.d;
          ls_m[m]  = e.s;
          qv_m[m]  = 1'b1;
          if (m == 0) ptr_m[m] = (w + 1) % N;
        end else begin
          qv_m[m] = 1'b0;
        end
      end
    end
  endtask

  // One cycle: drive inputs after the falling edge, then check and advance the model.
  task automatic step(input logic rstn, input logic [N-1:0] v, input logic [N*W-1:0] d,
                      input logic qr);
    @(negedge Clk);
    nReset   = rstn;
    In_valid = v;
    In_data  = d;
    Q_ready  = qr;
    #1;
    eval_dut(0, rdy_a, q_a, qv_a, sel_a);
    eval_dut(1, rdy_b, q_b, qv_b, sel_b);
  endtask

  // Round-robin monitor: compare the word being taken just before the rising edge.
  always begin
    @(negedge Clk);
    #4;
    if (nReset === 1'b1 && qv_a === 1'b1 && Q_ready === 1'b1) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rr_scoreboard: got word %0h, expected no word", q_a);
      end else begin
        mon_a = exp_a.pop_front();
        chk("rr_q",   32'(q_a),   32'(mon_a.d));
        chk("rr_sel", 32'(sel_a), 32'(mon_a.s));
      end
    end
  end

  // Fixed-priority monitor.
  always begin
    @(negedge Clk);
    #4;
    if (nReset === 1'b1 && qv_b === 1'b1 && Q_ready === 1'b1) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fix_scoreboard: got word %0h, expected no word", q_b);
      end else begin
        mon_b = exp_b.pop_front();
        chk("fix_q",   32'(q_b),   32'(mon_b.d));
        chk("fix_sel", 32'(sel_b), 32'(mon_b.s));
      end
    end
  end

  logic [N*W-1:0] d4;
  logic [63:0]    rnd;

  initial begin
    nReset   = 1'b0;
    In_valid = 4'hF;
    In_data  = '0;
    Q_ready  = 1'b0;
    ptr_m    = '{0, 0};
    qv_m     = '{1'b0, 1'b0};
    lq_m     = '{12'h000, 12'h000};
    ls_m     = '{2'd0, 2'd0};
    d4       = {12'h444, 12'h333, 12'h222, 12'h111};

    // Reset held with every channel requesting
    step(1'b0, 4'hF, d4, 1'b1);
    step(1'b0, 4'hF, d4, 1'b1);

    // Single request on ch2 in the first cycle after release
    step(1'b1, 4'b0100, {12'h000, 12'h123, 12'h000, 12'h000}, 1'b1);
    chk("single_in_ready", 32'(rdy_a), 32'h4);
    step(1'b1, 4'b0000, '0, 1'b1);
    chk("single_q",   32'(q_a),   32'h123);
    chk("single_sel", 32'(sel_a), 32'd2);

    // Round-robin over all four channels from a fresh pointer
    step(1'b0, 4'h0, '0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 4'hF, d4, 1'b1);

    // Backpressure: 777 held while ch1 waits, then loads without a gap
    step(1'b1, 4'b0001, {36'h0, 12'h777}, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0010, {24'h0, 12'h0AB, 12'h000}, 1'b0);
    chk("bp_q", 32'(q_a), 32'h777);
    step(1'b1, 4'b0010, {24'h0, 12'h0AB, 12'h000}, 1'b1);
    step(1'b1, 4'b0000, '0, 1'b1);
    chk("bp_load", 32'(q_a), 32'h0AB);

    // Fixed priority contention between ch0 and ch3
    for (int i = 0; i < 5; i++) step(1'b1, 4'b1001, {12'h999, 24'h0, 12'h555}, 1'b1);

    // Reset while a word is held
    step(1'b1, 4'b0000, '0, 1'b1);
    step(1'b1, 4'b0001, {36'h0, 12'h020}, 1'b0);
    step(1'b1, 4'b0000, '0, 1'b0);
    chk("mid_q_before", 32'(q_a), 32'h020);
    step(1'b0, 4'b1010, {12'hD03, 12'h000, 12'hD01, 12'h000}, 1'b0);
    step(1'b1, 4'b1010, {12'hD03, 12'h000, 12'hD01, 12'h000}, 1'b1);
    chk("mid_first_grant", 32'(rdy_a), 32'h2);
    step(1'b1, 4'b0000, '0, 1'b1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      rnd = {$urandom, $urandom};
      step(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)),
           rnd[N*W-1:0],
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end

    // Drain and confirm every expected word was delivered
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, '0, 1'b1);
    chk("rr_drain",  32'(exp_a.size()), 32'd0);
    chk("fix_drain", 32'(exp_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
